delay_mem_arbiter: RTL and testbench
====================================

Name: delay_mem_arbiter

Overview:
- Shares the single delay-line memory between DSP pipeline A, DSP pipeline B and a background zero-fill sequencer.
- The control unit drives the zero-fill when it allocates delay for a reconfigured pipeline.
- Issues at most one memory operation per cycle: round-robin between the pipelines, zero-fill only in otherwise idle cycles.
- Routes read data back to the issuing pipeline after a fixed memory latency.

Parameters:
- data_width, 16, sample/word width.
- addr_width, 16, delay memory address width.
- mem_latency, 2, cycles from mem_en (read) to valid mem_rdata; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- a_req  in  1  pipeline A request; held with a_we/a_addr/a_wdata stable until a_ack.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  addr_width  address.
- a_wdata  in  data_width  write data.
- a_ack  out  1  one-cycle pulse: request issued to memory this cycle.
- a_rdata  out  data_width  read data.
- a_rvalid  out  1  one-cycle pulse: a_rdata valid.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, b_rvalid: identical set for pipeline B.
- clear_start  in  1  pulse: begin zero-fill.
- clear_base  in  addr_width  first address to zero.
- clear_len  in  addr_width+1  number of words to zero.
- clear_busy  out  1  zero-fill in progress.
- clear_done  out  1  one-cycle pulse on completion.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  addr_width  memory address.
- mem_wdata  out  data_width  memory write data.
- mem_rdata  in  data_width  memory read data, valid mem_latency cycles after mem_en with mem_we=0.

Behaviour:
- Reset (reset low, async): all outputs 0; tag pipeline flushed; round-robin pointer = A; FSM = IDLE.
  - In-flight reads are discarded: no rvalid follows.
  - Any active zero-fill is aborted with no clear_done.
- Arbitration (edge t): candidate requesters are those with req=1 and ack currently 0. Masking a requester whose ack is high prevents double-issue of a held request.
  - One candidate: it wins.
  - Both A and B: the one not last granted wins; pointer updates on every pipeline grant.
  - Neither, FSM in CLEAR: zero-fill issues a write.
- Issue is registered. In cycle t+1 the following are high together for exactly one cycle:
  - mem_en;
  - mem_we/mem_addr/mem_wdata of the winner;
  - the winner's ack.
- Idle cycle: mem_en=0; mem_we=0; address/data hold their last value.
- Per-requester throughput: one op per 2 cycles. Interleaved A/B reaches 1 op/cycle.
- Read return:
  - A shift register of {valid, id} of depth mem_latency, loaded when mem_en&~mem_we.
  - When the tag exits, the matching x_rvalid pulses and x_rdata = mem_rdata in that same cycle (combinational path from mem_rdata).
  - x_rdata holds its value otherwise.
  - Writes produce no rvalid.
- Zero-fill FSM, states IDLE and CLEAR:
  - IDLE --clear_start--> CLEAR: latch base into ptr, latch len into remaining; clear_busy=1 from the next cycle.
  - clear_start in CLEAR is ignored.
  - clear_start with len=0: clear_busy high for one cycle, then clear_done, back to IDLE, no writes.
  - CLEAR: each idle arbitration slot issues mem_we=1, mem_addr=ptr, mem_wdata=0. Then ptr increments modulo 2^addr_width (wraps 0xFFFF→0x0000) and remaining decrements.
  - When the last write issues: clear_done pulses in the cycle after that write's mem_en; clear_busy falls in the same cycle; return to IDLE.
  - Pipeline accesses inside the region being cleared are not blocked. Ordering is issue order.
- Simultaneous clear_start and pipeline requests: clear is latched, pipelines are granted first.
- Starvation: the zero-fill may be starved by continuous requests. This is accepted because pipelines access memory only during sample processing.

Decomposition:
- Shared engine header (package): requester id constants (ID_A=0, ID_B=1), FSM state constants DELAY_ARB_IDLE and DELAY_ARB_CLEAR.
- One sub-module: delay_arb_tag_pipe, the parameterised {valid, id} shift register of depth mem_latency.

Test Plan:
- Single A read, addr 0x0010, mem model returns 0x1234 at latency 2:
  - a_ack and mem_en high one cycle after the request.
  - a_rvalid pulses 2 cycles later with a_rdata=0x1234.
  - b_rvalid stays 0.
- A and B requesting continuously:
  - Grants alternate A,B,A,B; mem_en high every cycle.
  - No requester acked twice for one held request.
- clear_start, base=0xFFFE, len=4, no pipeline traffic:
  - Writes of 0 to 0xFFFE, 0xFFFF, 0x0000, 0x0001 on consecutive cycles.
  - clear_done one cycle after the last write; clear_busy low from then.
- Zero-fill with base=0x0100, len=8 while A requests every other cycle:
  - Clear writes occupy only cycles A does not.
  - All 8 addresses written; A latency unaffected.
- clear_start with len=0 → clear_busy one cycle, then clear_done, no mem_en.
- Reset asserted one cycle after a B read issue:
  - No b_rvalid ever appears.
  - All outputs 0 while reset is low.
  - First post-reset request with A and B simultaneous is granted to A.

Source files
------------

// File: rtl/delay_mem_arbiter_pkg.sv
// Shared definitions for the delay-line memory arbiter: requester ids and
// zero-fill sequencer states.
package delay_mem_arbiter_pkg;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    typedef enum logic {
        DELAY_ARB_IDLE  = 1'b0,
        DELAY_ARB_CLEAR = 1'b1
    } arb_state_e;

endpackage

// File: rtl/delay_mem_arbiter_if.sv
// Bundle of the two pipeline ports, the zero-fill control port and the
// delay-memory port. "slave" is the arbiter side, "master" the environment.
interface delay_mem_arbiter_if #(
    parameter int unsigned data_width = 16,
    parameter int unsigned addr_width = 16
);
    logic                  a_req;
    logic                  a_we;
    logic [addr_width-1:0] a_addr;
    logic [data_width-1:0] a_wdata;
    logic                  a_ack;
    logic [data_width-1:0] a_rdata;
    logic                  a_rvalid;

    logic                  b_req;
    logic                  b_we;
    logic [addr_width-1:0] b_addr;
    logic [data_width-1:0] b_wdata;
    logic                  b_ack;
    logic [data_width-1:0] b_rdata;
    logic                  b_rvalid;

    logic                  clear_start;
    logic [addr_width-1:0] clear_base;
    logic [addr_width:0]   clear_len;
    logic                  clear_busy;
    logic                  clear_done;

    logic                  mem_en;
    logic                  mem_we;
    logic [addr_width-1:0] mem_addr;
    logic [data_width-1:0] mem_wdata;
    logic [data_width-1:0] mem_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata, a_rvalid,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata, b_rvalid,
        input  clear_start, clear_base, clear_len,
        output clear_busy, clear_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata, a_rvalid,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata, b_rvalid,
        output clear_start, clear_base, clear_len,
        input  clear_busy, clear_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/delay_arb_tag_pipe.sv
// {valid, id} shift register that tracks outstanding reads so returning data
// can be steered to the pipeline that issued it.
module delay_arb_tag_pipe #(
    parameter int unsigned depth = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_id,
    output logic out_valid,
    output logic out_id
);

    logic [depth-1:0] valid_q, valid_d;
    logic [depth-1:0] id_q, id_d;

    always_comb begin
        valid_d[0] = in_valid;
        id_d[0]    = in_id;
        for (int i = 1; i < int'(depth); i++) begin
            valid_d[i] = valid_q[i-1];
            id_d[i]    = id_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            id_q    <= '0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    assign out_valid = valid_q[depth-1];
    assign out_id    = id_q[depth-1];

endmodule

// File: rtl/delay_mem_arbiter.sv
// Single-port delay-memory arbiter: round-robin between pipelines A and B,
// background zero-fill in idle slots, read data steered back by tag.
module delay_mem_arbiter
    import delay_mem_arbiter_pkg::*;
#(
    parameter int unsigned data_width  = 16,
    parameter int unsigned addr_width  = 16,
    parameter int unsigned mem_latency = 2
) (
    input logic                clk,
    input logic                rst_n,
    delay_mem_arbiter_if.slave bus
);

    arb_state_e            state_q, state_d;
    logic [addr_width-1:0] ptr_q, ptr_d;
    logic [addr_width:0]   remaining_q, remaining_d;
    logic                  clear_busy_q, clear_busy_d;
    logic                  clear_done_q, clear_done_d;
    logic                  prio_q, prio_d;  // requester favoured when both compete
    logic                  a_ack_q, a_ack_d;
    logic                  b_ack_q, b_ack_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [addr_width-1:0] mem_addr_q, mem_addr_d;
    logic [data_width-1:0] mem_wdata_q, mem_wdata_d;
    logic [data_width-1:0] a_rdata_q, a_rdata_d;
    logic [data_width-1:0] b_rdata_q, b_rdata_d;

    logic cand_a, cand_b;
    logic grant_a, grant_b, grant_clr;
    logic tag_valid, tag_id;
    logic a_rvalid, b_rvalid;

    // A requester whose ack is high this cycle is still holding the request
    // it was just granted, so it must not be considered again.
    always_comb begin
        cand_a    = bus.a_req & ~a_ack_q;
        cand_b    = bus.b_req & ~b_ack_q;
        grant_a   = cand_a & (~cand_b | (prio_q == ID_A));
        grant_b   = cand_b & (~cand_a | (prio_q == ID_B));
        grant_clr = ~cand_a & ~cand_b & (state_q == DELAY_ARB_CLEAR) &
                    (remaining_q != '0);
    end

    always_comb begin
        a_ack_d     = grant_a;
        b_ack_d     = grant_b;
        mem_en_d    = grant_a | grant_b | grant_clr;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        prio_d      = prio_q;
        if (grant_a) begin
            mem_we_d    = bus.a_we;
            mem_addr_d  = bus.a_addr;
            mem_wdata_d = bus.a_wdata;
            prio_d      = ID_B;
        end else if (grant_b) begin
            mem_we_d    = bus.b_we;
            mem_addr_d  = bus.b_addr;
            mem_wdata_d = bus.b_wdata;
            prio_d      = ID_A;
        end else if (grant_clr) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ptr_q;
            mem_wdata_d = '0;
        end
    end

    // Completion is seen one cycle after the last write issues (remaining has
    // reached zero), which also covers a zero-length request.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        remaining_d  = remaining_q;
        clear_busy_d = clear_busy_q;
        clear_done_d = 1'b0;
        unique case (state_q)
            DELAY_ARB_IDLE: begin
                if (bus.clear_start) begin
                    state_d      = DELAY_ARB_CLEAR;
                    ptr_d        = bus.clear_base;
                    remaining_d  = bus.clear_len;
                    clear_busy_d = 1'b1;
                end
            end
            DELAY_ARB_CLEAR: begin
                if (remaining_q == '0) begin
                    state_d      = DELAY_ARB_IDLE;
                    clear_busy_d = 1'b0;
                    clear_done_d = 1'b1;
                end else if (grant_clr) begin
                    ptr_d       = ptr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        a_rvalid  = tag_valid & (tag_id == ID_A);
        b_rvalid  = tag_valid & (tag_id == ID_B);
        a_rdata_d = a_rvalid ? bus.mem_rdata : a_rdata_q;
        b_rdata_d = b_rvalid ? bus.mem_rdata : b_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= DELAY_ARB_IDLE;
            ptr_q        <= '0;
            remaining_q  <= '0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
            prio_q       <= ID_A;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            remaining_q  <= remaining_d;
            clear_busy_q <= clear_busy_d;
            clear_done_q <= clear_done_d;
            prio_q       <= prio_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    delay_arb_tag_pipe #(
        .depth(mem_latency)
    ) u_tag_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (mem_en_q & ~mem_we_q),
        .in_id    (a_ack_q ? ID_A : ID_B),
        .out_valid(tag_valid),
        .out_id   (tag_id)
    );

    assign bus.a_ack      = a_ack_q;
    assign bus.b_ack      = b_ack_q;
    assign bus.a_rvalid   = a_rvalid;
    assign bus.b_rvalid   = b_rvalid;
    assign bus.a_rdata    = a_rdata_d;
    assign bus.b_rdata    = b_rdata_d;
    assign bus.clear_busy = clear_busy_q;
    assign bus.clear_done = clear_done_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_delay_mem_arbiter.sv
// Directed bench for delay_mem_arbiter: per-cycle vector table for pipeline
// arbitration and read return, plus hand sequences for zero-fill and reset.
module tb_delay_mem_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    delay_mem_arbiter_if #(.data_width(16), .addr_width(16)) bus ();

    delay_mem_arbiter #(
        .data_width (16),
        .addr_width (16),
        .mem_latency(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_val(input logic [15:0] addr);
        return addr ^ 16'h1224;
    endfunction

    // Memory model with two cycles of read latency.
    logic [15:0] rd0_q, rd1_q;
    always @(posedge clk) begin
        rd1_q <= rd0_q;
        rd0_q <= (bus.mem_en && !bus.mem_we) ? mem_val(bus.mem_addr) : 16'hDEAD;
    end
    assign bus.mem_rdata = rd1_q;

    typedef struct packed {
        logic        a_req;
        logic        a_we;
        logic [15:0] a_addr;
        logic [15:0] a_wdata;
        logic        b_req;
        logic        b_we;
        logic [15:0] b_addr;
        logic [15:0] b_wdata;
        logic        x_a_ack;
        logic        x_b_ack;
        logic        x_en;
        logic        x_we;
        logic [15:0] x_addr;
        logic [15:0] x_wdata;
        logic        x_a_rv;
        logic        x_b_rv;
        logic [15:0] x_a_rd;
        logic [15:0] x_b_rd;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_addr;

        // a req/we/addr/wdata, b req/we/addr/wdata |
        // a_ack, b_ack, en, we, addr, wdata, a_rv, b_rv, a_rdata, b_rdata
        vecs[0]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                     1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                     1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                     1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'h0000};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                     1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h1234, 16'h0000};
        vecs[4]  = '{1'b1, 1'b1, 16'h0020, 16'hAAAA, 1'b1, 1'b1, 16'h0030, 16'hBBBB,
                     1'b0, 1'b1, 1'b1, 1'b1, 16'h0030, 16'hBBBB, 1'b0, 1'b0, 16'h1234, 16'h0000};
        vecs[5]  = '{1'b1, 1'b1, 16'h0020, 16'hAAAA, 1'b1, 1'b0, 16'h0031, 16'h0000,
                     1'b1, 1'b0, 1'b1, 1'b1, 16'h0020, 16'hAAAA, 1'b0, 1'b0, 16'h1234, 16'h0000};
        vecs[6]  = '{1'b1, 1'b0, 16'h0021, 16'h0000, 1'b1, 1'b0, 16'h0031, 16'h0000,
                     1'b0, 1'b1, 1'b1, 1'b0, 16'h0031, 16'h0000, 1'b0, 1'b0, 16'h1234, 16'h0000};
        vecs[7]  = '{1'b1, 1'b0, 16'h0021, 16'h0000, 1'b1, 1'b1, 16'h0032, 16'h0B0B,
                     1'b1, 1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000, 1'b0, 1'b0, 16'h1234, 16'h0000};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0032, 16'h0B0B,
                     1'b0, 1'b1, 1'b1, 1'b1, 16'h0032, 16'h0B0B, 1'b0, 1'b1, 16'h1234, 16'h1215};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                     1'b0, 1'b0, 1'b0, 1'b0, 16'h0032, 16'h0B0B, 1'b1, 1'b0, 16'h1205, 16'h1215};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                     1'b0, 1'b0, 1'b0, 1'b0, 16'h0032, 16'h0B0B, 1'b0, 1'b0, 16'h1205, 16'h1215};
        vecs[11] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                     1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h1205, 16'h1215};
        vecs[12] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                     1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h1205, 16'h1215};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                     1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0, 16'h1264, 16'h1215};
        vecs[14] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                     1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h1264, 16'h1215};

        rst_n           = 1'b0;
        bus.a_req       = 1'b0;
        bus.a_we        = 1'b0;
        bus.a_addr      = '0;
        bus.a_wdata     = '0;
        bus.b_req       = 1'b0;
        bus.b_we        = 1'b0;
        bus.b_addr      = '0;
        bus.b_wdata     = '0;
        bus.clear_start = 1'b0;
        bus.clear_base  = '0;
        bus.clear_len   = '0;

        step();
        step();
        chk("reset_a_ack", 32'(bus.a_ack), 32'(0));
        chk("reset_mem_en", 32'(bus.mem_en), 32'(0));
        chk("reset_mem_addr", 32'(bus.mem_addr), 32'(0));
        chk("reset_clear_busy", 32'(bus.clear_busy), 32'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            bus.a_req   = vecs[i].a_req;
            bus.a_we    = vecs[i].a_we;
            bus.a_addr  = vecs[i].a_addr;
            bus.a_wdata = vecs[i].a_wdata;
            bus.b_req   = vecs[i].b_req;
            bus.b_we    = vecs[i].b_we;
            bus.b_addr  = vecs[i].b_addr;
            bus.b_wdata = vecs[i].b_wdata;
            step();
            chk($sformatf("v%0d_a_ack", i), 32'(bus.a_ack), 32'(vecs[i].x_a_ack));
            chk($sformatf("v%0d_b_ack", i), 32'(bus.b_ack), 32'(vecs[i].x_b_ack));
            chk($sformatf("v%0d_mem_en", i), 32'(bus.mem_en), 32'(vecs[i].x_en));
            chk($sformatf("v%0d_mem_we", i), 32'(bus.mem_we), 32'(vecs[i].x_we));
            chk($sformatf("v%0d_mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].x_addr));
            chk($sformatf("v%0d_mem_wdata", i), 32'(bus.mem_wdata), 32'(vecs[i].x_wdata));
            chk($sformatf("v%0d_a_rvalid", i), 32'(bus.a_rvalid), 32'(vecs[i].x_a_rv));
            chk($sformatf("v%0d_b_rvalid", i), 32'(bus.b_rvalid), 32'(vecs[i].x_b_rv));
            chk($sformatf("v%0d_a_rdata", i), 32'(bus.a_rdata), 32'(vecs[i].x_a_rd));
            chk($sformatf("v%0d_b_rdata", i), 32'(bus.b_rdata), 32'(vecs[i].x_b_rd));
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;

        // Zero-fill across the top of the address space.
        bus.clear_start = 1'b1;
        bus.clear_base  = 16'hFFFE;
        bus.clear_len   = 17'd4;
        step();
        bus.clear_start = 1'b0;
        chk("wrap_busy_start", 32'(bus.clear_busy), 32'(1));
        chk("wrap_en_start", 32'(bus.mem_en), 32'(0));
        for (int i = 0; i < 4; i++) begin
            step();
            exp_addr = 16'hFFFE + 16'(i);
            chk($sformatf("wrap%0d_en", i), 32'(bus.mem_en), 32'(1));
            chk($sformatf("wrap%0d_we", i), 32'(bus.mem_we), 32'(1));
            chk($sformatf("wrap%0d_addr", i), 32'(bus.mem_addr), 32'(exp_addr));
            chk($sformatf("wrap%0d_wdata", i), 32'(bus.mem_wdata), 32'(0));
            chk($sformatf("wrap%0d_done", i), 32'(bus.clear_done), 32'(0));
        end
        step();
        chk("wrap_end_en", 32'(bus.mem_en), 32'(0));
        chk("wrap_end_done", 32'(bus.clear_done), 32'(1));
        chk("wrap_end_busy", 32'(bus.clear_busy), 32'(0));
        step();
        chk("wrap_after_done", 32'(bus.clear_done), 32'(0));

        // Zero-fill sharing slots with A requesting every other cycle; a second
        // clear_start while busy must be ignored.
        for (int i = 0; i < 16; i++) begin
            bus.clear_start = (i == 0) || (i == 5);
            bus.clear_base  = (i == 0) ? 16'h0100 : 16'h0BAD;
            bus.clear_len   = (i == 0) ? 17'd8 : 17'd3;
            bus.a_req       = (i % 2 == 0);
            bus.a_we        = 1'b0;
            bus.a_addr      = 16'h0200 + 16'(i / 2);
            step();
            chk($sformatf("mix%0d_busy", i), 32'(bus.clear_busy), 32'(1));
            chk($sformatf("mix%0d_en", i), 32'(bus.mem_en), 32'(1));
            chk($sformatf("mix%0d_wdata", i), 32'(bus.mem_wdata), 32'(0));
            if (i % 2 == 0) begin
                exp_addr = 16'h0200 + 16'(i / 2);
                chk($sformatf("mix%0d_a_ack", i), 32'(bus.a_ack), 32'(1));
                chk($sformatf("mix%0d_we", i), 32'(bus.mem_we), 32'(0));
            end else begin
                exp_addr = 16'h0100 + 16'((i - 1) / 2);
                chk($sformatf("mix%0d_a_ack", i), 32'(bus.a_ack), 32'(0));
                chk($sformatf("mix%0d_we", i), 32'(bus.mem_we), 32'(1));
            end
            chk($sformatf("mix%0d_addr", i), 32'(bus.mem_addr), 32'(exp_addr));
            chk($sformatf("mix%0d_a_rvalid", i), 32'(bus.a_rvalid),
                32'((i >= 2) && (i % 2 == 0)));
            if ((i >= 2) && (i % 2 == 0)) begin
                chk($sformatf("mix%0d_a_rdata", i), 32'(bus.a_rdata),
                    32'(mem_val(16'h0200 + 16'((i - 2) / 2))));
            end
        end
        bus.clear_start = 1'b0;
        bus.a_req       = 1'b0;
        step();
        chk("mix_end_done", 32'(bus.clear_done), 32'(1));
        chk("mix_end_busy", 32'(bus.clear_busy), 32'(0));
        chk("mix_end_en", 32'(bus.mem_en), 32'(0));
        chk("mix_end_a_rvalid", 32'(bus.a_rvalid), 32'(1));
        chk("mix_end_a_rdata", 32'(bus.a_rdata), 32'(mem_val(16'h0207)));
        step();
        chk("mix_after_done", 32'(bus.clear_done), 32'(0));
        chk("mix_after_en", 32'(bus.mem_en), 32'(0));

        // Zero-length fill.
        bus.clear_start = 1'b1;
        bus.clear_base  = 16'h0500;
        bus.clear_len   = 17'd0;
        step();
        bus.clear_start = 1'b0;
        chk("len0_busy", 32'(bus.clear_busy), 32'(1));
        chk("len0_en0", 32'(bus.mem_en), 32'(0));
        step();
        chk("len0_done", 32'(bus.clear_done), 32'(1));
        chk("len0_busy_low", 32'(bus.clear_busy), 32'(0));
        chk("len0_en1", 32'(bus.mem_en), 32'(0));
        step();
        chk("len0_done_low", 32'(bus.clear_done), 32'(0));
        chk("len0_en2", 32'(bus.mem_en), 32'(0));

        // B read and a long fill in flight, then reset before the read returns.
        bus.b_req       = 1'b1;
        bus.b_we        = 1'b0;
        bus.b_addr      = 16'h0050;
        bus.clear_start = 1'b1;
        bus.clear_base  = 16'h0300;
        bus.clear_len   = 17'd100;
        step();
        bus.b_req       = 1'b0;
        bus.clear_start = 1'b0;
        chk("rst_pre_b_ack", 32'(bus.b_ack), 32'(1));
        chk("rst_pre_addr", 32'(bus.mem_addr), 32'(16'h0050));
        step();
        chk("rst_pre_clr_we", 32'(bus.mem_we), 32'(1));
        chk("rst_pre_clr_addr", 32'(bus.mem_addr), 32'(16'h0300));
        rst_n = 1'b0;
        #1;
        chk("rst_a_ack", 32'(bus.a_ack), 32'(0));
        chk("rst_b_ack", 32'(bus.b_ack), 32'(0));
        chk("rst_mem_en", 32'(bus.mem_en), 32'(0));
        chk("rst_mem_we", 32'(bus.mem_we), 32'(0));
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'(0));
        chk("rst_busy", 32'(bus.clear_busy), 32'(0));
        chk("rst_done", 32'(bus.clear_done), 32'(0));
        chk("rst_a_rvalid", 32'(bus.a_rvalid), 32'(0));
        chk("rst_b_rvalid", 32'(bus.b_rvalid), 32'(0));
        chk("rst_a_rdata", 32'(bus.a_rdata), 32'(0));
        chk("rst_b_rdata", 32'(bus.b_rdata), 32'(0));
        bus.a_req  = 1'b1;
        bus.a_we   = 1'b0;
        bus.a_addr = 16'h0060;
        bus.b_req  = 1'b1;
        bus.b_addr = 16'h0070;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst%0d_en", i), 32'(bus.mem_en), 32'(0));
            chk($sformatf("rst%0d_a_ack", i), 32'(bus.a_ack), 32'(0));
            chk($sformatf("rst%0d_b_rvalid", i), 32'(bus.b_rvalid), 32'(0));
            chk($sformatf("rst%0d_busy", i), 32'(bus.clear_busy), 32'(0));
        end
        rst_n = 1'b1;
        step();
        chk("post_a_ack", 32'(bus.a_ack), 32'(1));
        chk("post_b_ack", 32'(bus.b_ack), 32'(0));
        chk("post_addr", 32'(bus.mem_addr), 32'(16'h0060));
        chk("post_b_rvalid0", 32'(bus.b_rvalid), 32'(0));
        bus.a_req = 1'b0;
        step();
        chk("post_b_ack2", 32'(bus.b_ack), 32'(1));
        chk("post_addr2", 32'(bus.mem_addr), 32'(16'h0070));
        bus.b_req = 1'b0;
        step();
        chk("post_idle_en", 32'(bus.mem_en), 32'(0));
        chk("post_busy", 32'(bus.clear_busy), 32'(0));
        chk("post_a_rvalid", 32'(bus.a_rvalid), 32'(1));
        chk("post_a_rdata", 32'(bus.a_rdata), 32'(mem_val(16'h0060)));
        chk("post_b_rvalid1", 32'(bus.b_rvalid), 32'(0));
        step();
        chk("post_b_rvalid2", 32'(bus.b_rvalid), 32'(1));
        chk("post_b_rdata", 32'(bus.b_rdata), 32'(mem_val(16'h0070)));
        chk("post_done", 32'(bus.clear_done), 32'(0));
        chk("post_idle_en2", 32'(bus.mem_en), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
